sa_result_writer: RTL and testbench
===================================

# sa_result_writer

Write-back engine on the result side of the systolic array: it accepts one drained 4x4 block of 16-bit results (four 64-bit rows) from the array and stores it into the single-port B-matrix region of sp-RAM. Each row is optionally accumulated lane-wise with the word already in RAM via a read-modify-write. It is the store-side counterpart of the controller that streams A/S operands into the array, and shares its B-region block addressing.

## Interface
- BASEADDR_B, 32'd86016 (1344*8*8), word address of the B region in sp-RAM
- BLK_PAIR_STRIDE, 32'd512, address step per pair of result blocks
- HALF_OFFSET, 32'd64, extra offset for odd block index
- ROW_STRIDE, 32'd128, address step between block rows

- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- wb_start  in  1  one-cycle start pulse; honoured only in IDLE
- blk_idx  in  10  result block index, sampled with wb_start
- accum_en  in  1  1: add to existing RAM word; 0: overwrite; sampled with wb_start
- res_valid  in  1  drain beat valid
- res_data  in  64  drain row, four 16-bit lanes, lane 0 in [15:0]
- res_ready  out  1  beat accepted when res_valid && res_ready
- mem_addr  out  32  sp-RAM word address
- mem_rdata  in  64  sp-RAM read data, one-cycle latency after mem_addr
- mem_wdata  out  64  sp-RAM write data
- mem_wen  out  1  sp-RAM write enable
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, COLLECT, RD, WR, DONE. Registers: blk latch (10b), acc latch, row buffer 4x64, row counter r (2b).
- IDLE: wb_start -> latch blk_idx/accum_en, r=0, go COLLECT. Other inputs ignored.
- COLLECT: res_ready=1. Each handshake stores res_data into buffer[r], r++. Handshake with r==3 -> r wraps to 0, go RD. res_valid low: hold.
- RD: mem_addr = row address of r, mem_wen=0; go WR.
- WR: mem_addr unchanged; mem_wen=1; mem_wdata = acc ? lane-wise (mem_rdata[16i+:16] + buffer[r][16i+:16]) mod 2^16 : buffer[r]. r==3 -> DONE, else r++ and go RD.
- DONE: done=1, go IDLE.
- Row address(r) = BASEADDR_B + (blk>>1)*BLK_PAIR_STRIDE + blk[0]*HALF_OFFSET + (3-r)*ROW_STRIDE, 32-bit unsigned; first drained row lands at the highest row offset.
- Lane adds are independent; carries never cross lanes; overflow wraps silently.
- RD cycle is executed even when acc=0 (fixed 8-cycle write phase).

## Timing
- Reset values: res_ready=0, mem_addr=0, mem_wdata=0, mem_wen=0, busy=0, done=0; state IDLE, r=0, buffer cleared.
- mem_addr/mem_wdata are 0 in IDLE, COLLECT, DONE.
- wb_start at cycle T -> COLLECT at T+1. With res_valid held high, beats accepted T+1..T+4; RD/WR pairs T+5..T+12 (writes at T+6, T+8, T+10, T+12); done at T+13; IDLE at T+14. Minimum 14 cycles start-to-IDLE.
- wb_start while busy: ignored, no relatch. wb_start coincident with done: ignored.
- res_valid outside COLLECT: ignored (res_ready=0), no buffer change.
- rst mid-operation: next cycle IDLE, mem_wen=0, no further writes; partial block discarded.
- blk_idx=1023: address = 86016+511*512+64+(3-r)*128, no truncation.

## Test plan
- Reset: assert rst 2 cycles during COLLECT -> all outputs 0, state IDLE, following wb_start works normally.
- Overwrite, blk_idx=0, accum_en=0, rows 0x1111..., 0x2222..., 0x3333..., 0x4444... -> writes at 86400/86272/86144/86016 with those rows; done at T+13.
- Accumulate, blk_idx=3, RAM preloaded 0x0001_0002_0003_FFFF, row 0x0001_0001_0001_0001 -> word 0x0002_0003_0004_0000 (lane 0 wraps) at 86016+512+64+384=86976.
- Stalled drain: res_valid toggling 1,0,0,1,1,0,1 -> exactly 4 beats captured in order, RD starts the cycle after the 4th beat.
- Ignored events: wb_start during WR and res_valid high in IDLE/RD -> no relatch, no extra writes, exactly 4 mem_wen pulses per block.
- Back-to-back: wb_start in cycle after done with blk_idx=1023 -> correct addresses, no lost or duplicate writes.

Source files
------------

// File: rtl/sa_result_writer_if.sv
// Handshake, drain and sp-RAM signals of the systolic-array result writer.
// The slave modport is the writer. The master modport is the controller/RAM side.
interface sa_result_writer_if;
   logic        wb_start;
   logic [9:0]  blk_idx;
   logic        accum_en;
   logic        res_valid;
   logic [63:0] res_data;
   logic        res_ready;
   logic [31:0] mem_addr;
   logic [63:0] mem_rdata;
   logic [63:0] mem_wdata;
   logic        mem_wen;
   logic        busy;
   logic        done;

   modport slave (
      input  wb_start, blk_idx, accum_en, res_valid, res_data, mem_rdata,
      output res_ready, mem_addr, mem_wdata, mem_wen, busy, done
   );

   modport master (
      output wb_start, blk_idx, accum_en, res_valid, res_data, mem_rdata,
      input  res_ready, mem_addr, mem_wdata, mem_wen, busy, done
   );
endinterface

// File: rtl/sa_result_writer.sv
// Collects one drained 4x4 block (four 64-bit rows) and writes it to the B region of sp-RAM.
// Each row is written with an RD/WR pair, optionally accumulating lane-wise with the stored word.
module sa_result_writer #(
   parameter logic [31:0] BASEADDR_B      = 32'd86016,
   parameter logic [31:0] BLK_PAIR_STRIDE = 32'd512,
   parameter logic [31:0] HALF_OFFSET     = 32'd64,
   parameter logic [31:0] ROW_STRIDE      = 32'd128
) (
   input  logic              clk,
   input  logic              rst,
   sa_result_writer_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_COLLECT = 3'd1,
      S_RD      = 3'd2,
      S_WR      = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [9:0]  blk_q, blk_d;
   logic        acc_q, acc_d;
   logic [1:0]  row_q, row_d;
   logic [63:0] buf_q [4];

   logic        beat_hs;
   logic [31:0] pair_off;
   logic [31:0] half_off;
   logic [31:0] row_off;
   logic [31:0] row_addr;
   logic [63:0] cur_row;
   logic [63:0] lane_sum;

   logic        res_ready;
   logic [31:0] mem_addr;
   logic [63:0] mem_wdata;
   logic        mem_wen;
   logic        busy;
   logic        done;

   assign beat_hs = (state_q == S_COLLECT) && bus.res_valid;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         blk_q   <= '0;
         acc_q   <= 1'b0;
         row_q   <= '0;
      end else begin
         state_q <= state_d;
         blk_q   <= blk_d;
         acc_q   <= acc_d;
         row_q   <= row_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      blk_d   = blk_q;
      acc_d   = acc_q;
      row_d   = row_q;
      case (state_q)
         S_IDLE: begin
            if (bus.wb_start) begin
               blk_d   = bus.blk_idx;
               acc_d   = bus.accum_en;
               row_d   = '0;
               state_d = S_COLLECT;
            end
         end
         S_COLLECT: begin
            if (bus.res_valid) begin
               row_d = row_q + 2'd1;
               if (row_q == 2'd3) begin
                  state_d = S_RD;
               end
            end
         end
         S_RD: begin
            state_d = S_WR;
         end
         S_WR: begin
            if (row_q == 2'd3) begin
               state_d = S_DONE;
            end else begin
               row_d   = row_q + 2'd1;
               state_d = S_RD;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            buf_q[i] <= '0;
         end
      end else if (beat_hs) begin
         buf_q[row_q] <= bus.res_data;
      end
   end

   // The first drained row lands at the highest row offset, so the row term is (3 - r).
   assign pair_off = {23'd0, blk_q[9:1]} * BLK_PAIR_STRIDE;
   assign half_off = blk_q[0] ? HALF_OFFSET : 32'd0;
   assign row_off  = {30'd0, ~row_q} * ROW_STRIDE;
   assign row_addr = BASEADDR_B + pair_off + half_off + row_off;

   assign cur_row = buf_q[row_q];

   // Independent 16-bit lanes: carries never cross lane boundaries.
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_sum[16*gi +: 16] = bus.mem_rdata[16*gi +: 16] + cur_row[16*gi +: 16];
   end

   // Output logic
   always_comb begin
      res_ready = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wen   = 1'b0;
      busy      = (state_q != S_IDLE);
      done      = 1'b0;
      case (state_q)
         S_COLLECT: res_ready = 1'b1;
         S_RD:      mem_addr  = row_addr;
         S_WR: begin
            mem_addr  = row_addr;
            mem_wen   = 1'b1;
            mem_wdata = acc_q ? lane_sum : cur_row;
         end
         S_DONE:    done = 1'b1;
         default: ;
      endcase
   end

   assign bus.res_ready = res_ready;
   assign bus.mem_addr  = mem_addr;
   assign bus.mem_wdata = mem_wdata;
   assign bus.mem_wen   = mem_wen;
   assign bus.busy      = busy;
   assign bus.done      = done;

endmodule

// File: tb/tb_sa_result_writer.sv
// Directed, table-driven bench for sa_result_writer with a one-cycle-latency sp-RAM model.
module tb_sa_result_writer;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   passed = 0;
   int   total = 0;

   sa_result_writer_if bus ();

   sa_result_writer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic        pre_we;
   logic [31:0] pre_addr;
   logic [63:0] pre_data;
   logic [63:0] mem [0:524287];
   logic [31:0] wlog_a [$];
   logic [63:0] wlog_d [$];
   int          wlog_c [$];

   always @(posedge clk) begin
      if (pre_we) begin
         mem[pre_addr[18:0]] <= pre_data;
      end else if (bus.mem_wen) begin
         mem[bus.mem_addr[18:0]] <= bus.mem_wdata;
         wlog_a.push_back(bus.mem_addr);
         wlog_d.push_back(bus.mem_wdata);
         wlog_c.push_back(cyc);
      end
      bus.mem_rdata <= mem[bus.mem_addr[18:0]];
      cyc <= cyc + 1;
   end

   typedef struct {
      logic [9:0]       blk;
      logic             acc;
      logic [15:0]      vpat;
      int               npat;
      logic             noise;
      logic             idle_chk;
      logic [3:0][63:0] row;
      logic [3:0][63:0] pre;
      logic [3:0][31:0] addr;
      logic [3:0][63:0] wdat;
      int               w0;
      int               dn;
   } vec_t;

   vec_t vecs [4];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) begin
         passed++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_vec(input int v, input logic [9:0] blk, input logic acc,
                          input logic [15:0] vpat, input int npat, input logic noise,
                          input logic idle_chk, input int w0, input int dn);
      vecs[v].blk      = blk;
      vecs[v].acc      = acc;
      vecs[v].vpat     = vpat;
      vecs[v].npat     = npat;
      vecs[v].noise    = noise;
      vecs[v].idle_chk = idle_chk;
      vecs[v].w0       = w0;
      vecs[v].dn       = dn;
   endtask

   task automatic set_row(input int v, input int r, input logic [63:0] row, input logic [63:0] pre,
                          input logic [31:0] addr, input logic [63:0] wdat);
      vecs[v].row[r]  = row;
      vecs[v].pre[r]  = pre;
      vecs[v].addr[r] = addr;
      vecs[v].wdat[r] = wdat;
   endtask

   task automatic chk_outputs_zero(input string pfx);
      chk({pfx, "_res_ready"}, 64'(bus.res_ready), 64'd0);
      chk({pfx, "_mem_addr"},  64'(bus.mem_addr),  64'd0);
      chk({pfx, "_mem_wdata"}, bus.mem_wdata,      64'd0);
      chk({pfx, "_mem_wen"},   64'(bus.mem_wen),   64'd0);
      chk({pfx, "_busy"},      64'(bus.busy),      64'd0);
      chk({pfx, "_done"},      64'(bus.done),      64'd0);
   endtask

   // Runs one block; entered and left at one time step after a rising edge.
   task automatic run_vec(input int v);
      int   t0, t_done, k, beat, prev, extra, s, n, pi;
      logic seen_done;
      s = wlog_a.size();
      if (vecs[v].noise) begin
         bus.res_valid = 1'b1;
         bus.res_data  = 64'hBAD0_BAD0_BAD0_BAD0;
         @(negedge clk);
         chk("idle_ready", 64'(bus.res_ready), 64'd0);
         @(posedge clk); #1;
         bus.res_valid = 1'b0;
      end
      t0 = cyc;
      bus.wb_start = 1'b1;
      bus.blk_idx  = vecs[v].blk;
      bus.accum_en = vecs[v].acc;
      beat = 0; extra = 0; k = 0; t_done = 0; seen_done = 1'b0;
      while (!seen_done && k < 60) begin
         @(posedge clk); #1;
         k++;
         bus.wb_start = vecs[v].noise && (k == 6);
         if (bus.wb_start) begin
            bus.blk_idx  = 10'd7;
            bus.accum_en = ~vecs[v].acc;
         end
         prev = beat;
         if (beat < 4) begin
            pi = k - 1;
            bus.res_valid = (pi < vecs[v].npat) ? vecs[v].vpat[pi] : 1'b1;
         end else begin
            bus.res_valid = vecs[v].noise;
         end
         bus.res_data = (beat < 4 && bus.res_valid) ? vecs[v].row[beat] : 64'hDEAD_BEEF_0BAD_F00D;
         @(negedge clk);
         if (bus.res_valid && bus.res_ready && beat < 4) beat++;
         if (prev == 4 && bus.res_ready) extra++;
         if (bus.done) begin
            seen_done = 1'b1;
            t_done    = cyc;
            if (vecs[v].noise) begin
               bus.wb_start = 1'b1;
               bus.blk_idx  = 10'd7;
            end
         end
      end
      @(posedge clk); #1;
      bus.wb_start  = 1'b0;
      bus.res_valid = 1'b0;
      if (!seen_done) begin
         $display("FAIL v%0d_timeout: no done within 60 cycles, expected done at +%0d", v, vecs[v].dn);
         total++;
      end else begin
         chk($sformatf("v%0d_done_lat", v), 64'(t_done - t0), 64'(vecs[v].dn));
      end
      chk($sformatf("v%0d_ready_after_collect", v), 64'(extra), 64'd0);
      if (vecs[v].idle_chk) begin
         @(negedge clk);
         chk($sformatf("v%0d_idle_busy", v), 64'(bus.busy), 64'd0);
         @(posedge clk); #1;
         @(negedge clk);
         chk($sformatf("v%0d_idle_busy2", v), 64'(bus.busy), 64'd0);
         @(posedge clk); #1;
      end
      n = wlog_a.size() - s;
      chk($sformatf("v%0d_nwrites", v), 64'(n), 64'd4);
      for (int i = 0; i < 4; i++) begin
         if (s + i < wlog_a.size()) begin
            chk($sformatf("v%0d_addr%0d", v, i), 64'(wlog_a[s+i]), 64'(vecs[v].addr[i]));
            chk($sformatf("v%0d_data%0d", v, i), wlog_d[s+i], vecs[v].wdat[i]);
         end
      end
      if (n > 0) begin
         chk($sformatf("v%0d_first_wr", v), 64'(wlog_c[s] - t0), 64'(vecs[v].w0));
      end
      $display("block %0d: blk=%0d acc=%0d writes=%0d done_at=+%0d", v, vecs[v].blk, vecs[v].acc,
               n, t_done - t0);
   endtask

   initial begin
      int s;
      rst = 1'b1;
      pre_we = 1'b0; pre_addr = '0; pre_data = '0;
      bus.wb_start = 1'b0; bus.blk_idx = '0; bus.accum_en = 1'b0;
      bus.res_valid = 1'b0; bus.res_data = '0;

      // blk 0 overwrite: rows land at 86400, 86272, 86144, 86016
      set_vec(0, 10'd0, 1'b0, 16'h0000, 0, 1'b0, 1'b1, 6, 13);
      set_row(0, 0, 64'h1111_1111_1111_1111, 64'h9999_9999_9999_9999, 32'd86400, 64'h1111_1111_1111_1111);
      set_row(0, 1, 64'h2222_2222_2222_2222, 64'h9999_9999_9999_9999, 32'd86272, 64'h2222_2222_2222_2222);
      set_row(0, 2, 64'h3333_3333_3333_3333, 64'h9999_9999_9999_9999, 32'd86144, 64'h3333_3333_3333_3333);
      set_row(0, 3, 64'h4444_4444_4444_4444, 64'h9999_9999_9999_9999, 32'd86016, 64'h4444_4444_4444_4444);
      // blk 3 accumulate with ignored events, followed back-to-back by blk 1023
      set_vec(1, 10'd3, 1'b1, 16'h0000, 0, 1'b1, 1'b0, 6, 13);
      set_row(1, 0, 64'h0001_0001_0001_0001, 64'h0001_0002_0003_FFFF, 32'd86976, 64'h0002_0003_0004_0000);
      set_row(1, 1, 64'h0001_0001_0001_0001, 64'hFFFF_FFFF_FFFF_FFFF, 32'd86848, 64'h0000_0000_0000_0000);
      set_row(1, 2, 64'h8000_0001_0020_1234, 64'h8000_7FFF_0010_0000, 32'd86720, 64'h0000_8000_0030_1234);
      set_row(1, 3, 64'h0000_0000_0000_0000, 64'h1234_5678_9ABC_DEF0, 32'd86592, 64'h1234_5678_9ABC_DEF0);
      // blk 1023 overwrite: 86016 + 511*512 + 64 = 347712 plus row offset
      set_vec(2, 10'd1023, 1'b0, 16'h0000, 0, 1'b0, 1'b1, 6, 13);
      set_row(2, 0, 64'h0123_4567_89AB_CDEF, 64'h5555_5555_5555_5555, 32'd348096, 64'h0123_4567_89AB_CDEF);
      set_row(2, 1, 64'hFEDC_BA98_7654_3210, 64'h5555_5555_5555_5555, 32'd347968, 64'hFEDC_BA98_7654_3210);
      set_row(2, 2, 64'h0F0F_F0F0_00FF_FF00, 64'h5555_5555_5555_5555, 32'd347840, 64'h0F0F_F0F0_00FF_FF00);
      set_row(2, 3, 64'h8000_0000_0000_0001, 64'h5555_5555_5555_5555, 32'd347712, 64'h8000_0000_0000_0001);
      // blk 5 accumulate with valid pattern 1,0,0,1,1,0,1
      set_vec(3, 10'd5, 1'b1, 16'h0059, 7, 1'b0, 1'b1, 9, 16);
      set_row(3, 0, 64'h1111_2222_3333_4444, 64'h0000_0000_0000_0000, 32'd87488, 64'h1111_2222_3333_4444);
      set_row(3, 1, 64'hFFFF_0000_FFFF_0001, 64'h0001_0001_0001_0001, 32'd87360, 64'h0000_0001_0000_0002);
      set_row(3, 2, 64'h0001_0001_0001_0001, 64'h7FFF_7FFF_7FFF_7FFF, 32'd87232, 64'h8000_8000_8000_8000);
      set_row(3, 3, 64'h0000_0000_0000_ABCD, 64'hABCD_0000_0000_0000, 32'd87104, 64'hABCD_0000_0000_ABCD);

      repeat (2) @(posedge clk);
      #1;
      for (int v = 0; v < 4; v++) begin
         for (int r = 0; r < 4; r++) begin
            pre_we   = 1'b1;
            pre_addr = vecs[v].addr[r];
            pre_data = vecs[v].pre[r];
            @(posedge clk); #1;
         end
      end
      pre_we = 1'b0;
      @(negedge clk);
      chk_outputs_zero("por");
      @(posedge clk); #1;
      rst = 1'b0;

      // Reset in the middle of COLLECT discards the partial block
      bus.wb_start = 1'b1; bus.blk_idx = 10'd0; bus.accum_en = 1'b0;
      @(posedge clk); #1;
      bus.wb_start = 1'b0; bus.res_valid = 1'b1; bus.res_data = 64'h7777_7777_7777_7777;
      @(posedge clk); #1;
      @(negedge clk);
      chk("mid_busy", 64'(bus.busy), 64'd1);
      chk("mid_ready", 64'(bus.res_ready), 64'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      s = wlog_a.size();
      @(posedge clk); #1;
      @(negedge clk);
      chk_outputs_zero("rst");
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_idle_busy", 64'(bus.busy), 64'd0);
      @(posedge clk); #1;
      bus.res_valid = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      chk("rst_no_writes", 64'(wlog_a.size() - s), 64'd0);
      $display("reset mid-collect: writes after reset=%0d", wlog_a.size() - s);

      for (int v = 0; v < 4; v++) begin
         run_vec(v);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
